// File: rtl/tb_sim_ctrl_periph.sv
// tb_sim_ctrl_periph
//   Memory-mapped simulation-control slave on the core data bus. Characters
//   written to PRINT are queued in a FIFO and streamed to a stdout sink.
//   Pass, fail and exit requests are latched. They become visible only after
//   the FIFO has drained, so all text is flushed before the simulation ends.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   data_req_i/gnt_o       bus request / combinational grant
//   data_rvalid_o          response strobe, one cycle after each grant
//   data_addr_i            byte address; bits [4:2] select the register
//   data_we_i, data_be_i   write enable, byte enables
//   data_wdata_i           write data
//   data_rdata_o           read data, valid with data_rvalid_o
//   stdout_valid_o/char_o  FIFO head character and its valid flag
//   stdout_ready_i         sink accepts the character
//   tests_passed_o         sticky pass, visible after drain
//   tests_failed_o         sticky fail, visible after drain
//   exit_valid_o           sticky exit, visible after drain
//   exit_value_o           exit code, zero until exit_valid_o
//
// Register map (addr[4:2]): 0 PRINT (WO), 1 TEST_STATUS (WO), 2 EXIT (WO),
//   3 CYCLE (RO), 4 FIFO_LEVEL (RO), 5-7 reserved.
module tb_sim_ctrl_periph #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_SIG   = 32'd123456789,
    parameter logic [31:0] FAIL_SIG   = 32'd1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        stdout_valid_o,
    output logic [7:0]  stdout_char_o,
    input  logic        stdout_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] REG_PRINT  = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_EXIT   = 3'd2;
    localparam logic [2:0] REG_CYCLE  = 3'd3;
    localparam logic [2:0] REG_LEVEL  = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             done;
    logic [2:0]       reg_sel;
    logic             fifo_full;
    logic             wr_gnt;
    logic             push;
    logic             pop;
    logic [31:0]      rd_mux;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [31:0]      cycle_q;
    logic             pass_q;
    logic             fail_q;
    logic             exit_q;
    logic [31:0]      exit_val_q;

    // Address bits outside the register select and the upper byte enables
    // carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{data_addr_i[31:5], data_addr_i[1:0], data_be_i[3:1]};

    assign reg_sel   = data_addr_i[4:2];
    assign fifo_full = (count_q == DEPTH_C);

    // A full FIFO stalls PRINT writes even if the sink pops in the same
    // cycle; this keeps the grant independent of stdout_ready_i.
    assign data_gnt_o = data_req_i & ~(data_we_i & (reg_sel == REG_PRINT) & fifo_full);
    assign wr_gnt     = data_gnt_o & data_we_i;
    assign push       = wr_gnt & (reg_sel == REG_PRINT) & data_be_i[0];
    assign pop        = stdout_valid_o & stdout_ready_i;

    assign stdout_valid_o = (count_q != '0);
    assign stdout_char_o  = fifo_mem[rd_ptr_q];

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_CYCLE: rd_mux = cycle_q;
            REG_LEVEL: rd_mux = 32'(count_q);
            default:   rd_mux = '0;
        endcase
    end

    // Bus response: one cycle after each grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= data_gnt_o;
            if (data_gnt_o) begin
                rdata_q <= data_we_i ? '0 : rd_mux;
            end
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

    // FIFO storage holds data only; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Cycle counter and sticky request flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q    <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            exit_q     <= 1'b0;
            exit_val_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (wr_gnt && reg_sel == REG_STATUS && data_wdata_i == PASS_SIG) pass_q <= 1'b1;
            if (wr_gnt && reg_sel == REG_STATUS && data_wdata_i == FAIL_SIG) fail_q <= 1'b1;
            // Only the first EXIT write counts.
            if (wr_gnt && reg_sel == REG_EXIT && !exit_q) begin
                exit_q     <= 1'b1;
                exit_val_q <= data_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pass_q || fail_q || exit_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A push in the emptying cycle means more text is still coming.
                if (count_q == '0 && !push) state_d = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign tests_passed_o = pass_q & done;
    assign tests_failed_o = fail_q & done;
    assign exit_valid_o   = exit_q & done;
    assign exit_value_o   = exit_valid_o ? exit_val_q : '0;

endmodule

// File: tb/tb_tb_sim_ctrl_periph.sv
// Testbench for tb_sim_ctrl_periph: directed bus transactions with a
// scoreboard. Expected read data and stdout characters are queued when a
// request is granted; a monitor pops and compares when the DUT responds.
module tb_tb_sim_ctrl_periph;

    localparam logic [31:0] PASS_SIG = 32'd123456789;
    localparam logic [31:0] FAIL_SIG = 32'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        so_valid;
    logic [7:0]  so_char;
    logic        so_ready = 1'b0;
    logic        passed;
    logic        failed;
    logic        exit_valid;
    logic [31:0] exit_value;

    int checks = 0;
    int errors = 0;

    bit          rsp_chk[$];
    logic [31:0] rsp_val[$];
    logic [7:0]  chr_q[$];
    logic [31:0] tb_cyc;
    logic [31:0] e;

    tb_sim_ctrl_periph #(
        .FIFO_DEPTH(16),
        .PASS_SIG  (PASS_SIG),
        .FAIL_SIG  (FAIL_SIG)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .data_req_i    (req),
        .data_gnt_o    (gnt),
        .data_rvalid_o (rvalid),
        .data_addr_i   (addr),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_wdata_i  (wdata),
        .data_rdata_o  (rdata),
        .stdout_valid_o(so_valid),
        .stdout_char_o (so_char),
        .stdout_ready_i(so_ready),
        .tests_passed_o(passed),
        .tests_failed_o(failed),
        .exit_valid_o  (exit_valid),
        .exit_value_o  (exit_value)
    );

    always #5 clk = ~clk;

    // Reference cycle count: number of clock edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge
    initial begin : monitor
        logic prev_gnt;
        prev_gnt = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_gnt = 1'b0;
            end else begin
                if (rvalid || prev_gnt) check("rvalid_timing", 32'(rvalid), 32'(prev_gnt));
                if (rvalid) begin
                    if (rsp_chk.size() == 0) begin
                        check("rsp_unexpected", 32'(rvalid), 32'd0);
                    end else begin
                        bit          c;
                        logic [31:0] v;
                        c = rsp_chk.pop_front();
                        v = rsp_val.pop_front();
                        if (c) check("rdata", rdata, v);
                    end
                end
                if (so_valid && so_ready) begin
                    if (chr_q.size() == 0) check("char_unexpected", 32'(so_char), 32'hFFFF_FFFF);
                    else                   check("stdout_char", 32'(so_char), 32'(chr_q.pop_front()));
                end
                prev_gnt = gnt;
            end
        end
    end

    // One bus transfer; expectations are queued once the grant is seen.
    task automatic bus(input bit align, input logic w, input logic [2:0] r, input logic [31:0] d,
                       input logic [3:0] b, input bit chk, input logic [31:0] exp);
        bit granted;
        granted = 1'b0;
        if (align) @(negedge clk);
        req = 1'b1; we = w; addr = {27'd0, r, 2'b00}; wdata = d; be = b;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (gnt) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!granted) begin
            check("gnt_timeout", 32'd0, 32'd1);
            req = 1'b0;
        end else begin
            rsp_chk.push_back(chk && !w);
            rsp_val.push_back(exp);
            if (w && r == 3'd0 && b[0]) chr_q.push_back(d[7:0]);
            @(posedge clk);
            #1;
            req = 1'b0;
        end
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        bus(1'b1, 1'b1, r, d, 4'hF, 1'b0, '0);
    endtask

    task automatic rd(input logic [2:0] r, input logic [31:0] exp);
        bus(1'b1, 1'b0, r, '0, 4'hF, 1'b1, exp);
    endtask

    task automatic wait_chars(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #3;
            if (chr_q.size() == 0) break;
        end
        check("chars_drained", chr_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0;
        so_ready = 1'b0;
        rsp_chk.delete();
        rsp_val.delete();
        chr_q.delete();
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_so_valid", 32'(so_valid), 32'd0);
        check("rst_passed", 32'(passed), 32'd0);
        check("rst_failed", 32'(failed), 32'd0);
        check("rst_exit_valid", 32'(exit_valid), 32'd0);
        check("rst_exit_value", exit_value, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        do_reset();

        // Reset values, read-only and write-only registers
        rd(3'd4, 32'd0);
        e = tb_cyc;
        rd(3'd3, e);
        rd(3'd0, 32'd0);
        rd(3'd6, 32'd0);
        wr(3'd4, 32'hDEAD_BEEF);
        rd(3'd4, 32'd0);
        bus(1'b1, 1'b1, 3'd0, 32'h41, 4'hE, 1'b0, '0);
        rd(3'd4, 32'd0);

        // Streaming characters with the sink ready
        so_ready = 1'b1;
        wr(3'd0, 32'h48);
        wr(3'd0, 32'h69);
        wr(3'd0, 32'h0A);
        wait_chars(20);

        // Unrecognised TEST_STATUS value changes nothing
        wr(3'd1, 32'd7);
        repeat (5) @(negedge clk);
        #1;
        check("status_other_pass", 32'(passed), 32'd0);
        check("status_other_fail", 32'(failed), 32'd0);

        // Fill the FIFO with the sink stalled
        so_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(3'd0, 32'h61 + i);
        rd(3'd4, 32'd16);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = '0; wdata = 32'h71; be = 4'h1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gnt_full", 32'(gnt), 32'd0);
            @(negedge clk);
        end
        so_ready = 1'b1;
        #1;
        check("gnt_same_cycle_pop", 32'(gnt), 32'd0);
        @(negedge clk);
        so_ready = 1'b0;
        #1;
        check("gnt_after_pop", 32'(gnt), 32'd1);
        if (gnt) begin
            rsp_chk.push_back(1'b0);
            rsp_val.push_back('0);
            chr_q.push_back(8'h71);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        rd(3'd4, 32'd16);
        so_ready = 1'b1;
        wait_chars(60);
        rd(3'd4, 32'd0);

        // Cycle counter spacing and wrap
        e = tb_cyc;
        rd(3'd3, e);
        repeat (9) @(posedge clk);
        rd(3'd3, e + 32'd10);
        force dut.cycle_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cycle_q;
        bus(1'b0, 1'b0, 3'd3, '0, 4'hF, 1'b1, 32'hFFFF_FFFF);
        rd(3'd3, 32'd0);
        rd(3'd3, 32'd1);

        // Pass is withheld until the FIFO drains
        so_ready = 1'b0;
        wr(3'd0, 32'h41);
        wr(3'd0, 32'h42);
        wr(3'd1, PASS_SIG);
        repeat (6) @(negedge clk);
        #1;
        check("pass_held", 32'(passed), 32'd0);
        check("pass_held_valid", 32'(so_valid), 32'd1);
        @(negedge clk);
        so_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!so_valid) break;
        end
        check("fifo_emptied", 32'(so_valid), 32'd0);
        check("pass_not_yet", 32'(passed), 32'd0);
        @(negedge clk);
        #1;
        check("pass_after_drain", 32'(passed), 32'd1);
        check("fail_clear", 32'(failed), 32'd0);
        check("exit_clear", 32'(exit_valid), 32'd0);
        check("exit_value_zero", exit_value, 32'd0);

        // First EXIT write wins
        wr(3'd2, 32'd5);
        @(negedge clk);
        #1;
        check("exit_valid", 32'(exit_valid), 32'd1);
        check("exit_value", exit_value, 32'd5);
        wr(3'd2, 32'd0);
        @(negedge clk);
        #1;
        check("exit_value_kept", exit_value, 32'd5);
        check("pass_sticky", 32'(passed), 32'd1);

        // Reset while draining with three characters queued
        do_reset();
        so_ready = 1'b0;
        wr(3'd0, 32'h78);
        wr(3'd0, 32'h79);
        wr(3'd0, 32'h7A);
        wr(3'd1, FAIL_SIG);
        repeat (3) @(negedge clk);
        #1;
        check("fail_held", 32'(failed), 32'd0);
        rd(3'd4, 32'd3);
        rd(3'd4, 32'd3);
        do_reset();
        rd(3'd4, 32'd0);
        wr(3'd0, 32'h72);
        wr(3'd1, FAIL_SIG);
        repeat (4) @(negedge clk);
        #1;
        check("run_after_reset", 32'(failed), 32'd0);
        so_ready = 1'b1;
        wait_chars(20);
        repeat (3) @(negedge clk);
        #1;
        check("fail_after_drain", 32'(failed), 32'd1);
        check("pass_after_reset", 32'(passed), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
